// File: rtl/fifo_pack_pkg.sv
// Shared types and width helpers for the FIFO read-side word packer.
package fifo_pack_pkg;

    typedef enum logic [1:0] {
        ACC_EMPTY = 2'd0,
        ACC_FILL  = 2'd1,
        ACC_FULL  = 2'd2,
        ACC_FLUSH = 2'd3
    } acc_state_t;

    // Width able to hold a word count from 0 up to and including ratio.
    function automatic int unsigned cnt_width(input int unsigned ratio);
        return $clog2(ratio + 32'd1);
    endfunction

    // Width of the idle counter, which only counts 0..timeout-1.
    function automatic int unsigned idle_width(input int unsigned timeout);
        return (timeout < 32'd2) ? 32'd1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/fifo_pack_out_reg.sv
// Valid/ready holding register for one packed word and its slice count.
module fifo_pack_out_reg #(
    parameter int unsigned DATA_W = 40,
    parameter int unsigned CNT_W  = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CNT_W-1:0]  count_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  count_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Load has priority; otherwise an accepted word frees the register.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        count_d = count_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            count_d = count_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Holding register state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign count_o = count_q;

endmodule

// File: rtl/fifo_read_packer.sv
// Pops narrow words from a first-word-fall-through FIFO read port and packs
// PACK_RATIO of them into one wide valid/ready word; partials leave on flush or idle timeout.
module fifo_read_packer
    import fifo_pack_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 10,
    parameter int unsigned PACK_RATIO = 4,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned CNT_BITS   = cnt_width(PACK_RATIO)
) (
    input  logic                            r_clk,
    input  logic                            r_reset,
    input  logic                            fifo_empty,
    input  logic [DATA_BITS-1:0]            fifo_data,
    output logic                            fifo_read,
    input  logic                            flush,
    output logic [DATA_BITS*PACK_RATIO-1:0] out_data,
    output logic [CNT_BITS-1:0]             out_count,
    output logic                            out_valid,
    input  logic                            out_ready
);

    localparam int unsigned WIDE_BITS = DATA_BITS * PACK_RATIO;
    localparam int unsigned IDLE_BITS = idle_width(TIMEOUT);
    localparam logic [CNT_BITS-1:0]  FULL_CNT  = CNT_BITS'(PACK_RATIO);
    localparam logic [CNT_BITS-1:0]  ONE_CNT   = CNT_BITS'(32'd1);
    localparam logic [IDLE_BITS-1:0] IDLE_ONE  = IDLE_BITS'(32'd1);
    localparam logic [IDLE_BITS-1:0] IDLE_LAST =
        IDLE_BITS'((TIMEOUT == 32'd0) ? 32'd0 : TIMEOUT - 32'd1);

    logic [WIDE_BITS-1:0] acc_data_q, acc_data_d;
    logic [CNT_BITS-1:0]  acc_cnt_q, acc_cnt_d;
    logic [IDLE_BITS-1:0] idle_cnt_q, idle_cnt_d;
    logic                 flush_pend_q, flush_pend_d;

    acc_state_t acc_state_s;
    logic       xfer_s;
    logic       pop_s;
    logic       idle_s;
    logic       timeout_hit_s;

    // Derived accumulator state; a pending flush overrides the fill level.
    always_comb begin
        acc_state_s = ACC_EMPTY;
        if (flush_pend_q) begin
            acc_state_s = ACC_FLUSH;
        end else if (acc_cnt_q == FULL_CNT) begin
            acc_state_s = ACC_FULL;
        end else if (acc_cnt_q != '0) begin
            acc_state_s = ACC_FILL;
        end else begin
            acc_state_s = ACC_EMPTY;
        end
    end

    // Transfer and pop decisions; pop is gated by reset so nothing is consumed while held.
    always_comb begin
        xfer_s = ((acc_state_s == ACC_FULL) ||
                  ((acc_state_s == ACC_FLUSH) && (acc_cnt_q != '0))) &&
                 (!out_valid || out_ready);
        pop_s  = r_reset && !fifo_empty && (acc_state_s != ACC_FLUSH) &&
                 ((acc_state_s != ACC_FULL) || xfer_s);
    end

    assign fifo_read = pop_s;

    // Accumulator: a word popped during a transfer starts the next group in slice 0.
    always_comb begin
        acc_data_d = acc_data_q;
        acc_cnt_d  = acc_cnt_q;
        if (xfer_s && pop_s) begin
            acc_data_d = {{(WIDE_BITS - DATA_BITS){1'b0}}, fifo_data};
            acc_cnt_d  = ONE_CNT;
        end else if (xfer_s) begin
            acc_data_d = '0;
            acc_cnt_d  = '0;
        end else if (pop_s) begin
            for (int k = 0; k < int'(PACK_RATIO); k++) begin
                if (CNT_BITS'(k) == acc_cnt_q) begin
                    acc_data_d[k*DATA_BITS +: DATA_BITS] = fifo_data;
                end else begin
                    acc_data_d[k*DATA_BITS +: DATA_BITS] = acc_data_q[k*DATA_BITS +: DATA_BITS];
                end
            end
            acc_cnt_d = acc_cnt_q + ONE_CNT;
        end else begin
            acc_data_d = acc_data_q;
            acc_cnt_d  = acc_cnt_q;
        end
    end

    // Idle timeout and flush request tracking.
    always_comb begin
        idle_s        = (acc_state_s == ACC_FILL) && !pop_s;
        timeout_hit_s = 1'b0;
        idle_cnt_d    = '0;
        if (TIMEOUT == 32'd0) begin
            idle_cnt_d = '0;
        end else if (!idle_s) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_LAST) begin
            timeout_hit_s = 1'b1;
            idle_cnt_d    = '0;
        end else begin
            idle_cnt_d = idle_cnt_q + IDLE_ONE;
        end

        flush_pend_d = flush_pend_q;
        if (flush || timeout_hit_s) begin
            flush_pend_d = 1'b1;
        end else if (xfer_s || (acc_cnt_q == '0)) begin
            flush_pend_d = 1'b0;
        end else begin
            flush_pend_d = flush_pend_q;
        end
    end

    // Accumulator, idle counter and flush state registers.
    always_ff @(posedge r_clk or negedge r_reset) begin
        if (!r_reset) begin
            acc_data_q   <= '0;
            acc_cnt_q    <= '0;
            idle_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            acc_data_q   <= acc_data_d;
            acc_cnt_q    <= acc_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    fifo_pack_out_reg #(
        .DATA_W (WIDE_BITS),
        .CNT_W  (CNT_BITS)
    ) u_out_reg (
        .clk_i   (r_clk),
        .rst_ni  (r_reset),
        .load_i  (xfer_s),
        .data_i  (acc_data_q),
        .count_i (acc_cnt_q),
        .ready_i (out_ready),
        .valid_o (out_valid),
        .data_o  (out_data),
        .count_o (out_count)
    );

endmodule

// File: tb/tb_fifo_read_packer.sv
// Directed and randomised self-checking bench for fifo_read_packer with a queue-based FIFO model.
module tb_fifo_read_packer;

    localparam int DB = 10;
    localparam int PR = 4;
    localparam int CB = 3;
    localparam int WB = DB * PR;

    logic          r_clk = 1'b0;
    logic          r_reset;
    logic          fifo_empty;
    logic [DB-1:0] fifo_data;
    logic          fifo_read;
    logic          flush;
    logic [WB-1:0] out_data;
    logic [CB-1:0] out_count;
    logic          out_valid;
    logic          out_ready;

    int checks   = 0;
    int failures = 0;

    logic [DB-1:0] fifo_q[$];
    logic [DB-1:0] sent_q[$];
    logic [WB-1:0] out_d_q[$];
    logic [CB-1:0] out_c_q[$];

    bit rd_hist[64];
    bit vld_hist[64];
    int first_vld, last_rd, n_rd, rd_run;

    bit            rd_s, vld_s, stall_prev;
    logic [WB-1:0] prev_data;
    logic [CB-1:0] prev_cnt;
    int            pushed;

    always #5 r_clk = ~r_clk;

    fifo_read_packer dut (
        .r_clk      (r_clk),
        .r_reset    (r_reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_read  (fifo_read),
        .flush      (flush),
        .out_data   (out_data),
        .out_count  (out_count),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fifo_refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? '0 : fifo_q[0];
    endtask

    task automatic push(input logic [DB-1:0] w);
        fifo_q.push_back(w);
        sent_q.push_back(w);
        fifo_refresh();
    endtask

    // Scoreboard: every valid slice must be the next word sent, unfilled slices zero.
    task automatic capture(input logic [WB-1:0] d, input logic [CB-1:0] c);
        logic [DB-1:0] sl;
        out_d_q.push_back(d);
        out_c_q.push_back(c);
        check_eq("cnt_range", (c >= 3'd1) && (c <= 3'd4), 64'd1);
        for (int j = 0; j < PR; j++) begin
            sl = d[j*DB +: DB];
            if (j < int'(c)) begin
                if (sent_q.size() == 0) check_eq("sb_underflow", 64'(sent_q.size()), 64'd1);
                else check_eq("sb_word", sl, sent_q.pop_front());
            end else begin
                check_eq("slice_zero", sl, 64'd0);
            end
        end
    endtask

    // One clock: sample at negedge, model the FIFO pop at posedge, return at posedge+1.
    task automatic step();
        @(negedge r_clk);
        rd_s  = fifo_read;
        vld_s = out_valid;
        if (stall_prev) begin
            check_eq("stall_valid", out_valid, 64'd1);
            check_eq("stall_data", out_data, prev_data);
            check_eq("stall_cnt", out_count, prev_cnt);
        end
        stall_prev = out_valid && !out_ready;
        prev_data  = out_data;
        prev_cnt   = out_count;
        if (out_valid && out_ready) capture(out_data, out_count);
        @(posedge r_clk);
        #1;
        if (rd_s) void'(fifo_q.pop_front());
        fifo_refresh();
    endtask

    task automatic run_cycles(input int n, input int fl);
        first_vld = -1;
        last_rd   = -1;
        n_rd      = 0;
        rd_run    = -1;
        for (int i = 0; i < n; i++) begin
            flush = (i == fl);
            step();
            rd_hist[i]  = rd_s;
            vld_hist[i] = vld_s;
            if (rd_s) begin
                n_rd++;
                last_rd = i;
            end else if (rd_run < 0) begin
                rd_run = i;
            end
            if (vld_s && first_vld < 0) first_vld = i;
        end
        flush = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        r_reset    = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b1;
        stall_prev = 1'b0;
        fifo_refresh();
        for (int i = 1; i <= 8; i++) push(DB'(i));

        // Reset state, FIFO already holding data.
        #2;
        check_eq("rst_fifo_read", fifo_read, 64'd0);
        check_eq("rst_out_valid", out_valid, 64'd0);
        check_eq("rst_out_data", out_data, 64'd0);
        check_eq("rst_out_count", out_count, 64'd0);
        @(posedge r_clk);
        @(posedge r_clk);
        #1;
        check_eq("rst_hold_read", fifo_read, 64'd0);
        r_reset = 1'b1;

        // Two full groups back to back.
        run_cycles(12, -1);
        check_eq("grp_rd_run", rd_run, 64'd8);
        check_eq("grp_vld_c4", vld_hist[4], 64'd0);
        check_eq("grp_vld_c5", vld_hist[5], 64'd1);
        check_eq("grp_n_out", out_d_q.size(), 64'd2);
        check_eq("grp_data0", out_d_q[0], {10'h004, 10'h003, 10'h002, 10'h001});
        check_eq("grp_data1", out_d_q[1], {10'h008, 10'h007, 10'h006, 10'h005});
        check_eq("grp_cnt0", out_c_q[0], 64'd4);
        check_eq("grp_cnt1", out_c_q[1], 64'd4);

        // Idle timeout on a 3-word partial.
        out_d_q.delete();
        out_c_q.delete();
        push(10'h0A1);
        push(10'h0A2);
        push(10'h0A3);
        run_cycles(24, -1);
        check_eq("to_last_rd", last_rd, 64'd2);
        check_eq("to_latency", first_vld - last_rd, 64'd18);
        check_eq("to_n_out", out_d_q.size(), 64'd1);
        check_eq("to_data", out_d_q[0], {10'h000, 10'h0A3, 10'h0A2, 10'h0A1});
        check_eq("to_cnt", out_c_q[0], 64'd3);

        // Explicit flush of a 2-word partial.
        push(10'h0B1);
        push(10'h0B2);
        run_cycles(4, -1);
        out_d_q.delete();
        out_c_q.delete();
        run_cycles(6, 0);
        check_eq("fl_latency", first_vld, 64'd2);
        check_eq("fl_n_out", out_d_q.size(), 64'd1);
        check_eq("fl_data", out_d_q[0], {10'h000, 10'h000, 10'h0B2, 10'h0B1});
        check_eq("fl_cnt", out_c_q[0], 64'd2);

        // Flush with nothing accumulated and nothing in the FIFO.
        out_d_q.delete();
        out_c_q.delete();
        run_cycles(6, 0);
        check_eq("fl_empty_novld", first_vld < 0, 64'd1);
        check_eq("fl_empty_nout", out_d_q.size(), 64'd0);

        // Back-pressure: 12 words, consumer stalled for 20 cycles.
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) push(DB'(32'h0C0 + i));
        run_cycles(20, -1);
        check_eq("stall_pops", n_rd, 64'd8);
        check_eq("stall_rd_end", rd_hist[19], 64'd0);
        check_eq("stall_vld_end", vld_hist[19], 64'd1);
        out_ready = 1'b1;
        run_cycles(20, -1);
        check_eq("stall_n_out", out_d_q.size(), 64'd3);
        check_eq("stall_data0", out_d_q[0], {10'h0C3, 10'h0C2, 10'h0C1, 10'h0C0});
        check_eq("stall_data2", out_d_q[2], {10'h0CB, 10'h0CA, 10'h0C9, 10'h0C8});
        check_eq("stall_sb_left", sent_q.size(), 64'd0);

        // Random traffic, random back-pressure and flushes.
        pushed = 0;
        for (int c = 0; c < 20000; c++) begin
            if (pushed == 1000 && fifo_q.size() == 0 && sent_q.size() == 0) break;
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 15) == 0);
            if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
                push(DB'($urandom_range(0, 1023)));
                pushed++;
            end
            step();
        end
        flush     = 1'b0;
        out_ready = 1'b1;
        check_eq("rnd_pushed", pushed, 64'd1000);
        check_eq("rnd_drain", sent_q.size(), 64'd0);
        run_cycles(4, -1);

        // Reset mid-group: output register held, two words in the accumulator.
        out_d_q.delete();
        out_c_q.delete();
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(DB'(32'h0D0 + i));
        run_cycles(6, -1);
        check_eq("mid_pre_pops", n_rd, 64'd6);
        check_eq("mid_pre_vld", vld_hist[5], 64'd1);
        r_reset = 1'b0;
        #1;
        check_eq("mid_rst_valid", out_valid, 64'd0);
        check_eq("mid_rst_count", out_count, 64'd0);
        check_eq("mid_rst_data", out_data, 64'd0);
        check_eq("mid_rst_read", fifo_read, 64'd0);
        for (int i = 0; i < 6; i++) void'(sent_q.pop_front());
        @(posedge r_clk);
        #1;
        r_reset    = 1'b1;
        stall_prev = 1'b0;
        out_ready  = 1'b1;
        run_cycles(24, -1);
        check_eq("mid_n_out", out_d_q.size(), 64'd1);
        check_eq("mid_data", out_d_q[0], {10'h000, 10'h000, 10'h0D8, 10'h0D7});
        check_eq("mid_cnt", out_c_q[0], 64'd2);
        check_eq("mid_sb_left", sent_q.size(), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
